// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired Moore control unit for the register-format ALU datapath.
//   Sequences fetch (T0-T2) and execute (T3-T6) and drives every bus,
//   register and ALU strobe of the datapath from the instruction in IR.
//
//   Strobes are a pure decode of the state register, plus the datapath's IR
//   register in T3 (the first cycle in which the new instruction is valid).
//   They therefore change only on clock edges and drop asynchronously with
//   reset. Fields needed after T3 are captured locally as T3 is left.
//
// Parameters
//   NREG      number of general registers (width of Rout/Rin)
//   WAIT_MAX  T1 hold cycles without mem_ready before a timeout fault
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low; clears all state and outputs
//   run        level; start/continue execution (sampled in IDLE and at completion)
//   mem_ready  memory read data valid (only used with WAIT_STATE_EN)
//   IR         instruction register from the datapath
//   PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin   fetch strobes
//   Yin, Zin, Zlowout, Zhighout, LOin, HIin                execute strobes
//   Rout / Rin one-hot register read select / write enable
//   alu_op     one-hot {NOT,NEG,ROL,ROR,SHL,SHRA,SHR,DIV,MUL,SUB,ADD,OR,AND}
//   busy       high in every state except IDLE and FAULT
//   fault      sticky; illegal opcode or memory timeout, cleared only by reset
//
// Build option
//   WAIT_STATE_EN  when defined, T1 holds until mem_ready and times out into
//                  FAULT after WAIT_MAX hold cycles; otherwise T1 is one cycle
//                  and mem_ready is ignored.
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int NREG     = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            IncPC,
  output logic            PCin,
  output logic            MARin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            LOin,
  output logic            HIin,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [12:0]     alu_op,
  output logic            busy,
  output logic            fault
);

  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHRA = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [4:0]       op_r;
  logic [3:0]       ra_r;
  logic [3:0]       rc_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_s;

  logic [4:0]       ir_op_s;
  logic [3:0]       ir_ra_s;
  logic [3:0]       ir_rb_s;
  logic [3:0]       ir_rc_s;
  logic             unused_s;

  assign ir_op_s = IR[31:27];
  assign ir_ra_s = IR[26:23];
  assign ir_rb_s = IR[22:19];
  assign ir_rc_s = IR[18:15];

`ifdef WAIT_STATE_EN
  assign unused_s = ^IR[14:0];
`else
  assign unused_s = ^{IR[14:0], mem_ready, wait_cnt_r};
`endif

  // One-hot ALU function select for an opcode; zero for non-ALU opcodes.
  function automatic logic [12:0] alu_onehot(input logic [4:0] op);
    logic [12:0] v;
    case (op)
      OP_AND:  v = 13'b0000000000001;
      OP_OR:   v = 13'b0000000000010;
      OP_ADD:  v = 13'b0000000000100;
      OP_SUB:  v = 13'b0000000001000;
      OP_MUL:  v = 13'b0000000010000;
      OP_DIV:  v = 13'b0000000100000;
      OP_SHR:  v = 13'b0000001000000;
      OP_SHRA: v = 13'b0000010000000;
      OP_SHL:  v = 13'b0000100000000;
      OP_ROR:  v = 13'b0001000000000;
      OP_ROL:  v = 13'b0010000000000;
      OP_NEG:  v = 13'b0100000000000;
      OP_NOT:  v = 13'b1000000000000;
      default: v = 13'b0000000000000;
    endcase
    return v;
  endfunction

  // Two-operand instructions: Rb goes to Y in T3, Rc through the ALU in T4.
  function automatic logic is_binary(input logic [4:0] op);
    logic v;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
      OP_ROL, OP_AND, OP_OR, OP_MUL, OP_DIV: v = 1'b1;
      default:                               v = 1'b0;
    endcase
    return v;
  endfunction

  // Single-operand instructions: ALU result formed in T3, T4 skipped.
  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Instructions whose result is split across LO and HI.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  // State register, wait counter and instruction fields captured on leaving T3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
      op_r       <= 5'd0;
      ra_r       <= 4'd0;
      rc_r       <= 4'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (state_r == S_T3) begin
        op_r <= ir_op_s;
        ra_r <= ir_ra_s;
        rc_r <= ir_rc_s;
      end else begin
        op_r <= op_r;
        ra_r <= ra_r;
        rc_r <= rc_r;
      end
    end
  end

  // Next-state logic; run is only consulted in IDLE and at instruction completion.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (run) state_s = S_T0;
        else     state_s = S_IDLE;
      end
      S_T0: begin
        wait_cnt_s = {CNT_W{1'b0}};
        state_s    = S_T1;
      end
      S_T1: begin
`ifdef WAIT_STATE_EN
        if (mem_ready) begin
          wait_cnt_s = {CNT_W{1'b0}};
          state_s    = S_T2;
        end else if (wait_cnt_r == CNT_W'(WAIT_MAX - 1)) begin
          state_s = S_FAULT;
        end else begin
          wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_s    = S_T1;
        end
`else
        state_s = S_T2;
`endif
      end
      S_T2: state_s = S_T3;
      S_T3: begin
        if (ir_op_s == OP_HALT)     state_s = S_IDLE;
        else if (is_unary(ir_op_s)) state_s = S_T5;
        else if (is_binary(ir_op_s)) state_s = S_T4;
        else                        state_s = S_FAULT;
      end
      S_T4: state_s = S_T5;
      S_T5: begin
        if (is_muldiv(op_r)) state_s = S_T6;
        else if (run)        state_s = S_T0;
        else                 state_s = S_IDLE;
      end
      S_T6: begin
        if (run) state_s = S_T0;
        else     state_s = S_IDLE;
      end
      S_FAULT: state_s = S_FAULT;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore strobe decode; every strobe defaults low so IDLE and FAULT drive nothing.
  always_comb begin
    PCout    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rout     = {NREG{1'b0}};
    Rin      = {NREG{1'b0}};
    alu_op   = 13'd0;
    busy     = (state_r != S_IDLE) && (state_r != S_FAULT);
    fault    = (state_r == S_FAULT);
    case (state_r)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_binary(ir_op_s)) begin
          Rout = reg_sel(ir_rb_s);
          Yin  = 1'b1;
        end else if (is_unary(ir_op_s)) begin
          Rout   = reg_sel(ir_rb_s);
          alu_op = alu_onehot(ir_op_s);
          Zin    = 1'b1;
        end else begin
          // HALT and illegal opcodes assert nothing while being decoded.
          Rout = {NREG{1'b0}};
        end
      end
      S_T4: begin
        Rout   = reg_sel(rc_r);
        alu_op = alu_onehot(op_r);
        Zin    = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv(op_r)) LOin = 1'b1;
        else                 Rin  = reg_sel(ra_r);
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: begin
        Zlowout = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Scoreboard bench. Programs of instructions are issued; a reference model
//   built from the instruction-level rules (which steps an instruction class
//   goes through and which strobes each step raises) pushes one expected
//   observation per clock cycle. A monitor pops and compares on every falling
//   edge. A small datapath model loads IR when IRin was high.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int NREG = 16;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            run       = 1'b0;
  logic            mem_ready = 1'b0;
  logic [31:0]     IR        = 32'd0;
  logic            PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
  logic            Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [NREG-1:0] Rout, Rin;
  logic [12:0]     alu_op;
  logic            busy, fault;

  control_sequencer #(.NREG(NREG), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcout, incpc, pcin, marin, read, mdrin, mdrout, irin;
    logic yin, zin, zlowout, zhighout, loin, hiin;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [12:0] alu;
    logic busy;
    logic fault;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] imem[$];
  logic [31:0] prog_q[$];
  int          total = 0;
  int          bad   = 0;
  string       mnem[logic [4:0]];
  string       alu_order[13];
  logic [4:0]  legal_ops[14];
  logic        load_pend = 1'b0;

  function automatic obs_t actual();
    obs_t o;
    o.pcout = PCout;  o.incpc = IncPC; o.pcin = PCin;  o.marin = MARin;
    o.read  = Read;   o.mdrin = MDRin; o.mdrout = MDRout; o.irin = IRin;
    o.yin   = Yin;    o.zin   = Zin;   o.zlowout = Zlowout; o.zhighout = Zhighout;
    o.loin  = LOin;   o.hiin  = HIin;
    o.rout  = Rout;   o.rin   = Rin;   o.alu = alu_op;
    o.busy  = busy;   o.fault = fault;
    return o;
  endfunction

  function automatic void check(string tag, obs_t got, obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endfunction

  function automatic void push(obs_t o, string tag);
    exp_t e;
    e.o   = o;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  function automatic string mn(logic [4:0] op);
    if (mnem.exists(op)) return mnem[op];
    return "ILL";
  endfunction

  function automatic logic [15:0] sel(int idx);
    logic [15:0] v;
    v = 16'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // ALU select bit = position counted from the right of the published list.
  function automatic logic [12:0] alu_bit(string m);
    logic [12:0] v;
    v = 13'd0;
    for (int p = 0; p < 13; p++)
      if (alu_order[p] == m) v[12-p] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] enc(logic [4:0] op, int ra, int rb, int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  // Reference model: expected per-cycle observations for one instruction.
  function automatic int model_instr(logic [31:0] ir, int idx);
    string m;
    string pfx;
    obs_t  o;
    int    ra, rb, rc, n;
    bit    unary, muldiv;
    m      = mn(ir[31:27]);
    ra     = int'(ir[26:23]);
    rb     = int'(ir[22:19]);
    rc     = int'(ir[18:15]);
    unary  = (m == "NEG") || (m == "NOT");
    muldiv = (m == "MUL") || (m == "DIV");
    pfx    = $sformatf("i%0d %s", idx, m);
    o = '0; o.busy = 1'b1; o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.pcin = 1'b1;
    push(o, {pfx, " T0"});
    o = '0; o.busy = 1'b1; o.read = 1'b1; o.mdrin = 1'b1;
    push(o, {pfx, " T1"});
    o = '0; o.busy = 1'b1; o.mdrout = 1'b1; o.irin = 1'b1;
    push(o, {pfx, " T2"});
    o = '0; o.busy = 1'b1;
    if (m == "HALT" || m == "ILL") begin
      push(o, {pfx, " T3"});
      return 4;
    end
    o.rout = sel(rb);
    if (unary) begin
      o.alu = alu_bit(m);
      o.zin = 1'b1;
    end else begin
      o.yin = 1'b1;
    end
    push(o, {pfx, " T3"});
    n = 4;
    if (!unary) begin
      o = '0; o.busy = 1'b1; o.rout = sel(rc); o.alu = alu_bit(m); o.zin = 1'b1;
      push(o, {pfx, " T4"});
      n++;
    end
    o = '0; o.busy = 1'b1; o.zlowout = 1'b1;
    if (muldiv) o.loin = 1'b1;
    else        o.rin  = sel(ra);
    push(o, {pfx, " T5"});
    n++;
    if (muldiv) begin
      o = '0; o.busy = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1;
      push(o, {pfx, " T6"});
      n++;
    end
    return n;
  endfunction

  // Monitor: one comparison per cycle while expectations are pending.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, actual(), e.o);
      end
    end
  end

  // Datapath model: IR loads at the edge that ends a cycle with IRin high.
  // mem_ready is toggled randomly to show it has no effect.
  initial begin
    forever begin
      @(negedge clk);
      load_pend = IRin;
      @(posedge clk);
      #1;
      if (load_pend && imem.size() > 0) IR = imem.pop_front();
      mem_ready = 1'($urandom);
    end
  end

  task automatic drain();
    int k;
    k = 0;
    repeat (2) @(posedge clk);
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #1;
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem.delete();
    exp_q.delete();
    #1;
    check("reset-async", actual(), '0);
    @(posedge clk);
    #1;
    check("reset-held", actual(), '0);
    run   = 1'b0;
    reset = 1'b1;
  endtask

  // Issue prog_q with run held high until the last instruction completes.
  task automatic run_prog();
    int   core;
    bit   ends_fault;
    obs_t o;
    core       = 0;
    ends_fault = 1'b0;
    push('0, "idle-start");
    for (int i = 0; i < prog_q.size(); i++) begin
      core += model_instr(prog_q[i], i);
      imem.push_back(prog_q[i]);
      if (mn(prog_q[i][31:27]) == "HALT" && i != prog_q.size() - 1) begin
        push('0, $sformatf("i%0d halt-idle", i));
        core++;
      end
      if (mn(prog_q[i][31:27]) == "ILL") ends_fault = 1'b1;
    end
    if (ends_fault) begin
      o = '0;
      o.fault = 1'b1;
      repeat (4) push(o, "fault-hold");
    end else begin
      repeat (2) push('0, "idle-end");
    end
    run = 1'b1;
    repeat (core) @(posedge clk);
    #1;
    run = 1'b0;
    drain();
    if (ends_fault) do_reset();
  endtask

  initial begin
    exp_t e4, e5;
    logic [4:0] bad_op;
    mnem[5'b00100] = "ADD";  mnem[5'b00101] = "SUB";  mnem[5'b00110] = "SHR";
    mnem[5'b00111] = "SHRA"; mnem[5'b01000] = "SHL";  mnem[5'b01001] = "ROR";
    mnem[5'b01010] = "ROL";  mnem[5'b01011] = "AND";  mnem[5'b01100] = "OR";
    mnem[5'b01111] = "MUL";  mnem[5'b10000] = "DIV";  mnem[5'b10001] = "NEG";
    mnem[5'b10010] = "NOT";  mnem[5'b11011] = "HALT";
    alu_order = '{"NOT", "NEG", "ROL", "ROR", "SHL", "SHRA", "SHR",
                  "DIV", "MUL", "SUB", "ADD", "OR", "AND"};
    legal_ops = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                  5'b01011, 5'b01100, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11011};

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset-state", actual(), '0);
    reset = 1'b1;

    // SUB R4,R5,R7
    prog_q = '{32'h2A2B8000};
    run_prog();
    // MUL R2,R3,R4: LO at T5, HI at T6, idle 7 cycles after T0
    prog_q = '{enc(5'b01111, 2, 3, 4)};
    run_prog();
    // NEG R1,R6: T4 skipped
    prog_q = '{enc(5'b10001, 1, 6, 0)};
    run_prog();
    // back-to-back ADDs then HALT, and HALT in the middle of a run
    prog_q = '{enc(5'b00100, 1, 2, 3), enc(5'b00100, 0, 0, 0), enc(5'b11011, 0, 0, 0)};
    run_prog();
    prog_q = '{enc(5'b00100, 9, 8, 7), enc(5'b11011, 0, 0, 0), enc(5'b10010, 15, 15, 0)};
    run_prog();

    // reset asserted while in T4: outputs clear at once and no Rin follows
    prog_q = '{enc(5'b00100, 4, 5, 6)};
    push('0, "idle-start");
    void'(model_instr(prog_q[0], 0));
    e5 = exp_q.pop_back();
    e4 = exp_q.pop_back();
    imem.push_back(prog_q[0]);
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort-in-T4", actual(), e4.o);
    do_reset();
    repeat (3) push('0, "post-reset-idle");
    drain();

    // illegal opcode 11111: sticky fault until reset
    prog_q = '{enc(5'b11111, 1, 2, 3)};
    run_prog();

    // randomized programs
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(1, 3);
      prog_q.delete();
      for (int j = 0; j < n; j++)
        prog_q.push_back(enc(legal_ops[$urandom_range(0, 13)], $urandom_range(0, 15),
                             $urandom_range(0, 15), $urandom_range(0, 15)));
      if (it % 10 == 9) begin
        do bad_op = 5'($urandom); while (mnem.exists(bad_op));
        prog_q.push_back(enc(bad_op, $urandom_range(0, 15), 0, 0));
      end
      run_prog();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
